uart_image_loader: RTL and testbench

//  Sequences the UART receiver byte stream into the input image RAM ahead of the downsampler.

---
 rtl/uart_image_loader.sv | 210 +++++++++++++++++++++
 tb/tb_uart_image_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_image_loader.sv
// uart_image_loader
//
// Purpose:
//   Moves the UART receiver byte stream into the input image RAM ahead of the
//   downsampler. After a start pulse it throws away whatever stale byte the
//   receiver is holding. It then hunts for the frame sync byte and writes the
//   next IMG_W*IMG_H bytes to consecutive RAM addresses starting at 0. It
//   raises done when the frame is complete. It raises sticky error flags when
//   the sync byte is wrong or when the byte stream stalls during the load.
//   This block drives the receiver's ready/ready_clr handshake, so the
//   receiver itself needs no changes.
//
// Ports:
//   clk_50m       in   1         system clock, 50 MHz
//   rst_n         in   1         asynchronous active-low reset
//   start         in   1         1-cycle pulse, load one frame (ignored while busy)
//   abort         in   1         1-cycle pulse, return to IDLE from any state
//   rx_ready      in   1         receiver byte-valid level
//   rx_data       in   8         receiver byte, valid while rx_ready=1
//   rx_ready_clr  out  1         1-cycle acknowledge pulse to the receiver
//   mem_we        out  1         RAM write strobe
//   mem_addr      out  ADDR_W    RAM write address
//   mem_wdata     out  8         RAM write data
//   busy          out  1         high in FLUSH/SYNC/LOAD
//   done          out  1         frame complete, sticky
//   err_sync      out  1         sticky, a non-sync byte arrived while hunting
//   err_timeout   out  1         sticky, byte stream stalled during LOAD
//   pix_count     out  ADDR_W+1  pixels written in the current frame
//
// Every output comes straight from a register.

module uart_image_loader #(
  parameter int unsigned IMG_W       = 256,
  parameter int unsigned IMG_H       = 256,
  parameter int unsigned ADDR_W      = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              rx_ready_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_sync,
  output logic              err_timeout,
  output logic [ADDR_W:0]   pix_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam logic [ADDR_W:0]   FRAME_PIX = (ADDR_W + 1)'(IMG_W * IMG_H);
  localparam int unsigned       TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q,     state_d;
  logic              rxClr_q,     rxClr_d;
  logic              memWe_q,     memWe_d;
  logic [ADDR_W-1:0] memAddr_q,   memAddr_d;
  logic [7:0]        memWdata_q,  memWdata_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              errSync_q,   errSync_d;
  logic              errTo_q,     errTo_d;
  logic [ADDR_W:0]   pixCount_q,  pixCount_d;
  logic [TO_W-1:0]   toCnt_q,     toCnt_d;
  logic [1:0]        blank_q,     blank_d;

  // The receiver only drops rx_ready one cycle after it sees rx_ready_clr.
  // rx_ready is therefore ignored for two cycles after every acknowledge,
  // and that includes the acknowledge sent in FLUSH. This stops the same
  // byte from being accepted twice.
  logic byteValid;
  assign byteValid = rx_ready && (blank_q == 2'd0);

  // Next-state logic. abort is checked first so it overrides any start,
  // byte or timeout event in the same cycle. abort only moves the state
  // machine. done, the error flags and pix_count keep their values so the
  // outcome of the interrupted frame can still be read.
  always_comb begin
    state_d    = state_q;
    rxClr_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    done_d     = done_q;
    errSync_d  = errSync_q;
    errTo_d    = errTo_q;
    pixCount_d = pixCount_q;
    toCnt_d    = toCnt_q;
    blank_d    = (blank_q != 2'd0) ? (blank_q - 2'd1) : 2'd0;

    if (abort) begin
      state_d = ST_IDLE;
      blank_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_d    = ST_FLUSH;
            rxClr_d    = 1'b1;
            blank_d    = 2'd2;
            done_d     = 1'b0;
            errSync_d  = 1'b0;
            errTo_d    = 1'b0;
            pixCount_d = '0;
            memAddr_d  = '0;
          end
        end
        ST_FLUSH: begin
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (byteValid) begin
            rxClr_d = 1'b1;
            blank_d = 2'd2;
            if (rx_data == SYNC_BYTE) begin
              state_d = ST_LOAD;
              toCnt_d = TO_W'(1);
            end else begin
              errSync_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // pix_count doubles as the write pointer. When the frame is
          // full, the state machine moves to DONE one cycle after the
          // last write, so done rises right after that last mem_we.
          // mem_addr is never pushed past the end of the frame.
          if (pixCount_q == FRAME_PIX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (byteValid) begin
            rxClr_d    = 1'b1;
            memWe_d    = 1'b1;
            memAddr_d  = pixCount_q[ADDR_W-1:0];
            memWdata_d = rx_data;
            pixCount_d = pixCount_q + 1'b1;
            blank_d    = 2'd2;
            toCnt_d    = TO_W'(1);
          end else if (toCnt_q >= TO_LAST) begin
            state_d = ST_ERROR;
            errTo_d = 1'b1;
          end else begin
            toCnt_d = toCnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_FLUSH) || (state_d == ST_SYNC) || (state_d == ST_LOAD);
  end

  // State and output registers. Reset drops everything to zero at once,
  // so a frame that was partly loaded is simply abandoned.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rxClr_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      errSync_q  <= 1'b0;
      errTo_q    <= 1'b0;
      pixCount_q <= '0;
      toCnt_q    <= '0;
      blank_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rxClr_q    <= rxClr_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      errSync_q  <= errSync_d;
      errTo_q    <= errTo_d;
      pixCount_q <= pixCount_d;
      toCnt_q    <= toCnt_d;
      blank_q    <= blank_d;
    end
  end

  assign rx_ready_clr = rxClr_q;
  assign mem_we       = memWe_q;
  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_sync     = errSync_q;
  assign err_timeout  = errTo_q;
  assign pix_count    = pixCount_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Testbench for uart_image_loader. It uses a 4x4 frame and a 1000-cycle
// timeout.
//
// The bench works as follows:
//  - A cycle-by-cycle vector table covers reset, flush, sync search, the
//    first write, abort during a byte accept, and start being ignored.
//  - A task plays the role of the UART receiver. It holds rx_ready until it
//    sees the acknowledge, then drops rx_ready one cycle later.
//  - A monitor compares every RAM write against a queue of expected
//    {address, data} pairs. Those pairs come from the frame rule: the k-th
//    byte after the first sync byte goes to address k.
//  - Random frames add a random number of junk bytes before the sync byte
//    and random gaps between bytes.
//  - Separate sequences cover the timeout latency, a long rx_ready hold,
//    and reset in the middle of a frame.

module tb_uart_image_loader;

  localparam int IMG_W       = 4;
  localparam int IMG_H       = 4;
  localparam int ADDR_W      = 4;
  localparam int FRAME       = IMG_W * IMG_H;
  localparam int TIMEOUT_CYC = 1000;
  localparam logic [7:0] SYNC = 8'hA5;

  logic              clk_50m = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              rx_ready_clr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              err_sync;
  logic              err_timeout;
  logic [ADDR_W:0]   pix_count;

  int checks = 0;
  int passes = 0;
  int cycleCnt = 0;
  int weCount = 0;
  int clrCount = 0;
  int lastWeCycle = 0;
  logic doneDue = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;
  wr_t expQ[$];

  typedef struct {
    logic       start;
    logic       abort;
    logic       rdy;
    logic [7:0] data;
    logic [9:0] expFlags;  // {busy, we, clr, done, err_sync, pix_count}
    logic [11:0] expWrite; // {mem_addr, mem_wdata}, used only when we is expected
  } vec_t;
  vec_t vecs[$];

  uart_image_loader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .abort(abort),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_ready_clr(rx_ready_clr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_sync(err_sync), .err_timeout(err_timeout),
    .pix_count(pix_count)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write monitor: each RAM write must match the next expected pair, and
  // done must rise in the cycle after the last pixel of the frame is written.
  always @(negedge clk_50m) begin
    if (rx_ready_clr) clrCount++;
    if (doneDue) begin
      checkOutput("done_after_last_write", 32'(done), 32'd1);
      doneDue = 1'b0;
    end
    if (mem_we) begin
      wr_t e;
      weCount++;
      lastWeCycle = cycleCnt;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr_data", 32'({mem_addr, mem_wdata}), 32'({e.addr, e.data}));
        if (32'(e.addr) == 32'(FRAME - 1)) begin
          checkOutput("done_low_on_last_write", 32'(done), 32'd0);
          doneDue = 1'b1;
        end
      end
    end
  end

  function automatic vec_t mkVec(input int st, input int ab, input int rdy, input int dat,
                                 input int bsy, input int we, input int clr, input int es,
                                 input int pix, input int wa, input int wd);
    vec_t v;
    v.start    = 1'(st);
    v.abort    = 1'(ab);
    v.rdy      = 1'(rdy);
    v.data     = 8'(dat);
    v.expFlags = {1'(bsy), 1'(we), 1'(clr), 1'b0, 1'(es), 5'(pix)};
    v.expWrite = {4'(wa), 8'(wd)};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    start    = v.start;
    abort    = v.abort;
    rx_ready = v.rdy;
    rx_data  = v.data;
    @(posedge clk_50m); #1;
    checkOutput($sformatf("vec%0d_flags", idx),
                32'({busy, mem_we, rx_ready_clr, done, err_sync, pix_count}), 32'(v.expFlags));
    if (v.expFlags[8])
      checkOutput($sformatf("vec%0d_write", idx), 32'({mem_addr, mem_wdata}), 32'(v.expWrite));
  endtask

  // Receiver model: present a byte after `gap` idle cycles, hold it until
  // the acknowledge appears, then drop rx_ready one cycle later.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit got = 0;
    repeat (gap) begin @(posedge clk_50m); #1; end
    rx_data  = b;
    rx_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk_50m); #1;
      if (rx_ready_clr) begin got = 1; break; end
    end
    if (!got) begin
      checks++;
      $display("[TB] FAIL ack_wait: got no rx_ready_clr within 50 cycles, expected one for byte %0h", b);
    end else begin
      @(posedge clk_50m); #1;
    end
    rx_ready = 1'b0;
  endtask

  task automatic startFrame();
    @(posedge clk_50m); #1;
    start = 1'b1;
    @(posedge clk_50m); #1;
    start = 1'b0;
  endtask

  task automatic abortFrame();
    @(posedge clk_50m); #1;
    abort = 1'b1;
    @(posedge clk_50m); #1;
    abort = 1'b0;
    checkOutput("abort_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got simulation still running at 1 ms, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  junk;
    int  weBase;
    int  clrBase;
    int  rise;
    logic [7:0] b;

    // Reset with the receiver holding a stale power-up byte.
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    repeat (3) @(posedge clk_50m);
    #1;
    checkOutput("reset_outputs",
                32'({rx_ready_clr, mem_we, mem_addr, mem_wdata, busy, done, err_sync, err_timeout, pix_count}), 32'd0);
    rst_n = 1'b1;

    // Cycle table: start, abort, rdy, data | busy, we, clr, err_sync, pix, addr, wdata
    vecs.push_back(mkVec(1,0,1,'h77, 1,0,1,0,0, 0,0));    // start accepted -> FLUSH acks the stale byte
    vecs.push_back(mkVec(0,0,1,'h77, 1,0,0,0,0, 0,0));    // SYNC, stale byte still up
    vecs.push_back(mkVec(0,0,0,'h00, 1,0,0,0,0, 0,0));
    vecs.push_back(mkVec(0,0,1,'h3C, 1,0,1,1,0, 0,0));    // wrong sync byte
    vecs.push_back(mkVec(0,0,1,'h3C, 1,0,0,1,0, 0,0));    // blanked
    vecs.push_back(mkVec(0,0,0,'h00, 1,0,0,1,0, 0,0));
    vecs.push_back(mkVec(0,0,1,'hA5, 1,0,1,1,0, 0,0));    // search continues, sync found
    vecs.push_back(mkVec(0,0,1,'hA5, 1,0,0,1,0, 0,0));
    vecs.push_back(mkVec(0,0,0,'h00, 1,0,0,1,0, 0,0));
    vecs.push_back(mkVec(0,0,1,'h5A, 1,1,1,1,1, 0,'h5A)); // first pixel at address 0
    vecs.push_back(mkVec(0,0,1,'h5A, 1,0,0,1,1, 0,0));
    vecs.push_back(mkVec(0,0,0,'h00, 1,0,0,1,1, 0,0));
    vecs.push_back(mkVec(0,1,1,'h11, 0,0,0,1,1, 0,0));    // abort beats the byte accept
    vecs.push_back(mkVec(0,0,1,'h11, 0,0,0,1,1, 0,0));    // IDLE does not ack
    vecs.push_back(mkVec(1,1,1,'h11, 0,0,0,1,1, 0,0));    // start with abort: abort wins
    vecs.push_back(mkVec(1,0,1,'h11, 1,0,1,0,0, 0,0));    // start clears flags and count
    vecs.push_back(mkVec(1,0,0,'h00, 1,0,0,0,0, 0,0));    // start while busy ignored
    vecs.push_back(mkVec(0,0,0,'h00, 1,0,0,0,0, 0,0));
    vecs.push_back(mkVec(0,0,1,'h22, 1,0,1,1,0, 0,0));
    expQ.push_back('{addr: 4'd0, data: 8'h5A});
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
    rx_ready = 1'b0;
    start    = 1'b0;
    abortFrame();

    // rx_ready held for three cycles after one byte: only one accept.
    startFrame();
    sendByte(SYNC, 1);
    weBase  = weCount;
    clrBase = clrCount;
    expQ.push_back('{addr: 4'd0, data: 8'h42});
    @(posedge clk_50m); #1;
    rx_data  = 8'h42;
    rx_ready = 1'b1;
    repeat (3) begin @(posedge clk_50m); #1; end
    rx_ready = 1'b0;
    repeat (3) begin @(posedge clk_50m); #1; end
    checkOutput("hold_single_we", 32'(weCount - weBase), 32'd1);
    checkOutput("hold_single_clr", 32'(clrCount - clrBase), 32'd1);
    abortFrame();

    // Random frames: junk bytes, then the sync byte, then a full frame of pixels.
    for (int f = 0; f < 4; f++) begin
      junk    = $urandom_range(0, 2);
      weBase  = weCount;
      clrBase = clrCount;
      startFrame();
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h3C;
        sendByte(b, $urandom_range(0, 4));
      end
      sendByte(SYNC, $urandom_range(0, 4));
      for (int p = 0; p < FRAME; p++) begin
        b = 8'($urandom_range(0, 255));
        expQ.push_back('{addr: 4'(p), data: b});
        sendByte(b, $urandom_range(0, 6));
      end
      for (int c = 0; c < 20 && !done; c++) begin @(posedge clk_50m); #1; end
      checkOutput($sformatf("frame%0d_status", f),
                  32'({busy, done, err_sync, err_timeout, pix_count}),
                  32'({1'b0, 1'b1, (junk > 0) ? 1'b1 : 1'b0, 1'b0, 5'(FRAME)}));
      checkOutput($sformatf("frame%0d_writes", f), 32'(weCount - weBase), 32'(FRAME));
      checkOutput($sformatf("frame%0d_acks", f), 32'(clrCount - clrBase), 32'(junk + FRAME + 2));
    end

    // Timeout: the stream stops after 5 pixels.
    startFrame();
    sendByte(SYNC, 1);
    for (int p = 0; p < 5; p++) begin
      b = 8'($urandom_range(0, 255));
      expQ.push_back('{addr: 4'(p), data: b});
      sendByte(b, 1);
    end
    rise = -1;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk_50m);
      if (err_timeout) begin rise = cycleCnt; break; end
    end
    checkOutput("timeout_latency", 32'(rise - lastWeCycle), 32'(TIMEOUT_CYC - 1));
    checkOutput("timeout_state", 32'({busy, done, err_timeout, pix_count}), 32'({1'b0, 1'b0, 1'b1, 5'd5}));
    startFrame();
    checkOutput("restart_from_error", 32'({busy, rx_ready_clr, err_timeout, pix_count}), 32'({1'b1, 1'b1, 1'b0, 5'd0}));
    abortFrame();

    // Reset in the middle of a frame, then a fresh frame starts again at address 0.
    startFrame();
    sendByte(SYNC, 1);
    expQ.push_back('{addr: 4'd0, data: 8'h10});
    expQ.push_back('{addr: 4'd1, data: 8'h20});
    sendByte(8'h10, 0);
    sendByte(8'h20, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("midframe_reset",
                32'({busy, mem_we, rx_ready_clr, done, err_sync, err_timeout, pix_count, mem_addr}), 32'd0);
    @(posedge clk_50m); #1;
    rst_n = 1'b1;
    startFrame();
    sendByte(SYNC, 1);
    expQ.push_back('{addr: 4'd0, data: 8'hC3});
    sendByte(8'hC3, 0);
    checkOutput("reload_pix_count", 32'(pix_count), 32'd1);
    abortFrame();

    checkOutput("expected_writes_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
